// File: rtl/sh7604_pkg.sv
// Shared SH7604 definitions: bus-state-controller state encoding, limits and
// a wait-state clamp helper used by the DBUS responder.
package sh7604_pkg;

  typedef enum logic [2:0] {
    BSC_IDLE     = 3'd0,
    BSC_ACCESS   = 3'd1,
    BSC_DONE     = 3'd2,
    BSC_RELEASED = 3'd3,
    BSC_TURN     = 3'd4
  } BSC_STATE_t;

  localparam int BSC_WS_MAX    = 7;
  localparam int BSC_BURST_LEN = 4;

  // Clamp a wait-state setting into the range of the 3-bit wait counter.
  function automatic logic [2:0] bsc_ws_clamp(input int ws);
    if (ws > BSC_WS_MAX) return 3'(BSC_WS_MAX);
    else if (ws < 0)     return 3'd0;
    else                 return 3'(ws);
  endfunction

endpackage

// File: rtl/sh7604_bsc_waitcnt.sv
// Wait-state counter for the bus state controller: 3-bit loadable
// down-counter advancing only on CE_R, with a zero flag that marks the
// end of the programmed wait states.
module sh7604_bsc_waitcnt (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       LOAD,
  input  logic [2:0] LOAD_VAL,
  input  logic       DEC,
  output logic       ZERO
);

  logic [2:0] cnt;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= 3'd0;
    end else if (CE_R) begin
      if (LOAD) begin
        cnt <= LOAD_VAL;
      end else if (DEC && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  assign ZERO = (cnt == 3'd0);

endmodule

// File: rtl/sh7604_dbus_resp.sv
// SH7604 DBUS responder: runs DBUS accesses on one external SRAM-style port
// with programmable wait states and burst beats, and hands the bus to an
// external master through BREQ_N/BACK_N when DBUS_LOCK is low.
// Optional macro SH7604_BSC_TURN_EN inserts one idle CE_R period (TURN,
// MEM_CS low) between a completed read and a following write.
//
// Handshake: the initiator holds DBUS_REQ with stable A/DO/BA/WE/BURST.
// DBUS_WAIT = DBUS_REQ & (state != DONE). The access is consumed while
// DBUS_WAIT is low with DBUS_REQ high (the DONE period); before the next
// CE_R the initiator must either drop DBUS_REQ or present the next access.
module sh7604_dbus_resp
  import sh7604_pkg::*;
#(
  parameter int WS       = 1,
  parameter int BURST_WS = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] DBUS_A,
  input  logic [31:0] DBUS_DO,
  input  logic [3:0]  DBUS_BA,
  input  logic        DBUS_WE,
  input  logic        DBUS_REQ,
  input  logic        DBUS_BURST,
  input  logic        DBUS_LOCK,
  output logic [31:0] DBUS_DI,
  output logic        DBUS_WAIT,
  output logic        BSC_ACK,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_CS,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_RDY,
  input  logic        BREQ_N,
  output logic        BACK_N,
  output logic [2:0]  DBG_STATE
);

  localparam logic [2:0] WS_L       = bsc_ws_clamp(WS);
  localparam logic [2:0] BURST_WS_L = bsc_ws_clamp(BURST_WS);
  localparam logic [1:0] LAST_BEAT  = 2'(BSC_BURST_LEN - 1);

  BSC_STATE_t state, state_nxt;
  logic       cnt_zero;
  logic       burst_prev;   // the beat just finished was a burst beat chained through DONE
  logic [1:0] beat_cnt;     // index of the current beat within a burst
  logic       grant, sample, launch, burst_cont, turn_needed, fin;

  assign grant      = !BREQ_N && !DBUS_LOCK;
  assign sample     = CE_R && ((state == BSC_IDLE) || (state == BSC_DONE));
  assign launch     = sample && !grant && DBUS_REQ;
  assign burst_cont = DBUS_BURST && burst_prev && (beat_cnt != LAST_BEAT);
  assign fin        = CE_R && (state == BSC_ACCESS) && cnt_zero && MEM_RDY;

`ifdef SH7604_BSC_TURN_EN
  logic last_read;

  // Remember whether the last completed external cycle was a read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_read <= 1'b0;
    end else if (fin) begin
      last_read <= !MEM_WE;
    end
  end

  assign turn_needed = last_read && DBUS_WE;
`else
  assign turn_needed = 1'b0;
`endif

  sh7604_bsc_waitcnt u_waitcnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .LOAD     (launch),
    .LOAD_VAL (burst_cont ? BURST_WS_L : WS_L),
    .DEC      (state == BSC_ACCESS),
    .ZERO     (cnt_zero)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= BSC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE samples new work with the same rules as IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      BSC_IDLE, BSC_DONE: begin
        if (CE_R) begin
          if (grant)         state_nxt = BSC_RELEASED;
          else if (DBUS_REQ) state_nxt = turn_needed ? BSC_TURN : BSC_ACCESS;
          else               state_nxt = BSC_IDLE;
        end
      end
      BSC_ACCESS: begin
        if (fin) state_nxt = DBUS_REQ ? BSC_DONE : BSC_IDLE;
      end
      BSC_RELEASED: begin
        if (CE_R && BREQ_N) state_nxt = BSC_IDLE;
      end
`ifdef SH7604_BSC_TURN_EN
      BSC_TURN: begin
        if (CE_R) state_nxt = BSC_ACCESS;
      end
`endif
      default: state_nxt = BSC_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    DBUS_WAIT = DBUS_REQ && (state != BSC_DONE);
    BSC_ACK   = (state == BSC_ACCESS) || (state == BSC_DONE);
    DBG_STATE = state;
  end

  // External strobes, read-data holding register, bus grant and burst tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_A      <= '0;
      MEM_DO     <= '0;
      MEM_BE     <= '0;
      MEM_WE     <= 1'b0;
      MEM_CS     <= 1'b0;
      DBUS_DI    <= '0;
      BACK_N     <= 1'b1;
      burst_prev <= 1'b0;
      beat_cnt   <= 2'd0;
    end else begin
      BACK_N <= (state_nxt != BSC_RELEASED);
      if (sample && grant) begin
        MEM_A      <= '0;
        MEM_DO     <= '0;
        MEM_BE     <= '0;
        MEM_WE     <= 1'b0;
        MEM_CS     <= 1'b0;
        burst_prev <= 1'b0;
        beat_cnt   <= 2'd0;
      end else if (launch) begin
        MEM_A    <= DBUS_A;
        MEM_DO   <= DBUS_DO;
        MEM_BE   <= DBUS_BA;
        MEM_WE   <= DBUS_WE;
        MEM_CS   <= !turn_needed;
        beat_cnt <= burst_cont ? (beat_cnt + 2'd1) : 2'd0;
      end else if (fin) begin
        // DBUS_DI only ever changes here, so it survives following writes.
        if (!MEM_WE) DBUS_DI <= MEM_DI;
        burst_prev <= DBUS_REQ && DBUS_BURST;
        if (!DBUS_REQ) MEM_CS <= 1'b0;
      end else if ((state == BSC_DONE) && CE_R) begin
        // Leaving DONE without a new access ends any burst chain.
        MEM_CS     <= 1'b0;
        burst_prev <= 1'b0;
      end else if ((state == BSC_DONE) && CE_F && !(DBUS_REQ && DBUS_BURST)) begin
        MEM_CS <= 1'b0;
      end
`ifdef SH7604_BSC_TURN_EN
      else if ((state == BSC_TURN) && CE_R) begin
        MEM_CS <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sh7604_dbus_resp.sv
// Self-checking bench for sh7604_dbus_resp (WS=2, BURST_WS=0): a table of
// single accesses plus hand-written burst, bus-release, stall, request-drop
// and reset sequences.
module tb_sh7604_dbus_resp;
  import sh7604_pkg::*;

  localparam int TB_WS = 2;
`ifdef SH7604_BSC_TURN_EN
  localparam int TURN_EN = 1;
`else
  localparam int TURN_EN = 0;
`endif

  logic        clk, rst_n, ce_r, ce_f, ce_ph;
  logic [31:0] dbus_a, dbus_do, mem_di;
  logic [3:0]  dbus_ba;
  logic        dbus_we, dbus_req, dbus_burst, dbus_lock, mem_rdy, breq_n;
  logic [31:0] dbus_di, mem_a, mem_do;
  logic [3:0]  mem_be;
  logic        dbus_wait, bsc_ack, mem_we, mem_cs, back_n;
  logic [2:0]  dbg_state;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  ba;
    logic [31:0] mem_di;
    logic [31:0] exp_di;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_miscompares;

  sh7604_dbus_resp #(.WS(TB_WS), .BURST_WS(0)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f),
    .DBUS_A(dbus_a), .DBUS_DO(dbus_do), .DBUS_BA(dbus_ba), .DBUS_WE(dbus_we),
    .DBUS_REQ(dbus_req), .DBUS_BURST(dbus_burst), .DBUS_LOCK(dbus_lock),
    .DBUS_DI(dbus_di), .DBUS_WAIT(dbus_wait), .BSC_ACK(bsc_ack),
    .MEM_A(mem_a), .MEM_DO(mem_do), .MEM_BE(mem_be), .MEM_WE(mem_we), .MEM_CS(mem_cs),
    .MEM_DI(mem_di), .MEM_RDY(mem_rdy), .BREQ_N(breq_n), .BACK_N(back_n),
    .DBG_STATE(dbg_state)
  );

  // Clock and reset-independent phase enables: CE_R and CE_F alternate per CLK.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce_ph = 1'b0;
    ce_r  = 1'b0;
    ce_f  = 1'b0;
    forever begin
      @(negedge clk);
      ce_r  = ce_ph;
      ce_f  = !ce_ph;
      ce_ph = !ce_ph;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_r();
    do @(posedge clk); while (!ce_r);
    #1;
  endtask

  task automatic next_f();
    do @(posedge clk); while (!ce_f);
    #1;
  endtask

  // One complete single access from IDLE, ending back in IDLE.
  task automatic run_single(input vec_t v, input int exp_lat, input logic exp_cs0);
    int          n;
    logic        ack_lost;
    logic [31:0] exp_di;
    ack_lost = 1'b0;
    exp_q.push_back(v.exp_di);
    dbus_a = v.a; dbus_do = v.d; dbus_ba = v.ba; dbus_we = v.we;
    mem_di = v.mem_di; dbus_req = 1'b1;
    next_r();
    check("launch_cs", 32'(mem_cs), 32'(exp_cs0));
    check("launch_ack", 32'(bsc_ack), 32'(exp_cs0));
    check("mem_a", mem_a, v.a);
    check("mem_be", 32'(mem_be), 32'(v.ba));
    check("mem_we", 32'(mem_we), 32'(v.we));
    check("mem_do", mem_do, v.d);
    n = 0;
    do begin
      next_r();
      n++;
      if (!bsc_ack) ack_lost = 1'b1;
    end while (dbus_wait && n < 40);
    check("latency", n, exp_lat);
    check("ack_held", 32'(ack_lost), 0);
    exp_di = exp_q.pop_front();
    check("dbus_di", dbus_di, exp_di);
    next_f();
    check("cs_release", 32'(mem_cs), 0);
    dbus_req = 1'b0;
    next_r();
    check("end_idle", 32'(dbg_state), 32'(BSC_IDLE));
    check("end_ack", 32'(bsc_ack), 0);
  endtask

  initial begin
    int   n, g;
    logic prev_read, flag_a, flag_b;
    n_checks = 0; n_miscompares = 0;
    rst_n = 1'b0; dbus_a = '0; dbus_do = '0; dbus_ba = '0; dbus_we = 1'b0;
    dbus_req = 1'b0; dbus_burst = 1'b0; dbus_lock = 1'b0; mem_di = '0;
    mem_rdy = 1'b1; breq_n = 1'b1;

    vecs[0] = '{we:1'b0, a:32'h0600_0004, d:32'h0,         ba:4'hF,    mem_di:32'hDEAD_BEEF, exp_di:32'hDEAD_BEEF};
    vecs[1] = '{we:1'b0, a:32'h0600_0010, d:32'h0,         ba:4'hF,    mem_di:32'h1122_3344, exp_di:32'h1122_3344};
    vecs[2] = '{we:1'b1, a:32'h0600_0020, d:32'hCAFE_F00D, ba:4'b0011, mem_di:32'h5555_5555, exp_di:32'h1122_3344};
    vecs[3] = '{we:1'b1, a:32'h0600_0024, d:32'h0BAD_F00D, ba:4'b1100, mem_di:32'h6666_6666, exp_di:32'h1122_3344};
    vecs[4] = '{we:1'b0, a:32'h2000_0000, d:32'h0,         ba:4'b0001, mem_di:32'h0000_0080, exp_di:32'h0000_0080};
    vecs[5] = '{we:1'b1, a:32'h2000_000C, d:32'hFFFF_0000, ba:4'hF,    mem_di:32'h0000_0000, exp_di:32'h0000_0080};

    // Reset values.
    #12;
    check("rst_dbus_di", dbus_di, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_cs", 32'(mem_cs), 0);
    check("rst_ack", 32'(bsc_ack), 0);
    check("rst_back_n", 32'(back_n), 1);
    check("rst_wait", 32'(dbus_wait), 0);
    check("rst_state", 32'(dbg_state), 32'(BSC_IDLE));
    #20 rst_n = 1'b1;
    next_r();

    // Table of single accesses.
    prev_read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic turn;
      turn = (TURN_EN != 0) && vecs[i].we && prev_read;
      run_single(vecs[i], TB_WS + 1 + (turn ? 1 : 0), !turn);
      prev_read = !vecs[i].we;
    end

    // Read followed directly by a write while DBUS_REQ stays high.
    dbus_a = 32'h0600_0040; dbus_we = 1'b0; dbus_ba = 4'hF; dbus_do = '0;
    mem_di = 32'h7E7E_0001; dbus_req = 1'b1;
    next_r();
    n = 0;
    do begin next_r(); n++; end while (dbus_wait && n < 40);
    check("b2b_read_lat", n, TB_WS + 1);
    next_f();
    dbus_a = 32'h0600_0044; dbus_we = 1'b1; dbus_do = 32'h0A0B_0C0D;
    dbus_ba = 4'b0110; mem_di = 32'h9999_9999;
    g = 0;
    do begin next_r(); g++; end while (!mem_cs && g < 10);
    check("rw_gap", g, 1 + TURN_EN);
    check("b2b_mem_a", mem_a, 32'h0600_0044);
    n = 0;
    do begin next_r(); n++; end while (dbus_wait && n < 40);
    check("b2b_write_lat", n, TB_WS + 1);
    check("b2b_di_held", dbus_di, 32'h7E7E_0001);
    check("b2b_mem_we", 32'(mem_we), 1);
    next_f();
    dbus_req = 1'b0;
    next_r();

    // Locked 4-beat burst with an external bus request arriving on beat 2.
    dbus_lock = 1'b1; dbus_burst = 1'b1; dbus_req = 1'b1; dbus_we = 1'b0; dbus_ba = 4'hF;
    flag_a = 1'b0; flag_b = 1'b0;
    for (int b = 0; b < 4; b++) begin
      dbus_a = 32'h0600_0100 + 32'(b * 4);
      mem_di = 32'hB000_0000 + 32'(b);
      next_r();
      check("burst_mem_a", mem_a, 32'h0600_0100 + 32'(b * 4));
      if (!mem_cs) flag_a = 1'b1;
      if (b == 1) breq_n = 1'b0;
      n = 0;
      do begin
        next_r();
        n++;
        if (!mem_cs) flag_a = 1'b1;
        if (!back_n) flag_b = 1'b1;
      end while (dbus_wait && n < 40);
      check("burst_lat", n, (b == 0) ? TB_WS + 1 : 1);
      check("burst_di", dbus_di, 32'hB000_0000 + 32'(b));
      next_f();
      if (!mem_cs) flag_a = 1'b1;
    end
    check("burst_cs_cont", 32'(flag_a), 0);
    check("locked_back_n", 32'(flag_b), 0);

    // Lock released with a new request pending: the external master wins.
    dbus_lock = 1'b0; dbus_burst = 1'b0; dbus_a = 32'h0600_0200; mem_di = 32'h600D_CAFE;
    next_r();
    check("grant_back_n", 32'(back_n), 0);
    check("grant_state", 32'(dbg_state), 32'(BSC_RELEASED));
    check("grant_wait", 32'(dbus_wait), 1);
    check("grant_mem_cs", 32'(mem_cs), 0);
    check("grant_mem_a", mem_a, 0);
    flag_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_r();
      if (!dbus_wait || back_n) flag_a = 1'b1;
    end
    check("released_hold", 32'(flag_a), 0);
    breq_n = 1'b1;
    next_r();
    check("reclaim_back_n", 32'(back_n), 1);
    check("reclaim_state", 32'(dbg_state), 32'(BSC_IDLE));
    check("reclaim_wait", 32'(dbus_wait), 1);
    next_r();
    check("held_req_mem_a", mem_a, 32'h0600_0200);
    n = 0;
    do begin next_r(); n++; end while (dbus_wait && n < 40);
    check("held_req_lat", n, TB_WS + 1);
    check("held_req_di", dbus_di, 32'h600D_CAFE);
    next_f();
    dbus_req = 1'b0;
    next_r();

    // MEM_RDY low for five CE_R periods after the wait states run out.
    dbus_a = 32'h0600_0300; dbus_we = 1'b0; mem_di = 32'h1234_5678; mem_rdy = 1'b0; dbus_req = 1'b1;
    next_r();
    n = 0;
    do begin
      next_r();
      n++;
      if (n == TB_WS + 1 + 4) mem_rdy = 1'b1;
    end while (dbus_wait && n < 40);
    check("rdy_stall_lat", n, TB_WS + 1 + 5);
    check("rdy_stall_di", dbus_di, 32'h1234_5678);
    next_f();
    dbus_req = 1'b0;
    next_r();

    // DBUS_REQ dropped mid-access: cycle still completes and data is captured.
    dbus_a = 32'h0600_0400; mem_di = 32'h0F0F_0F0F; dbus_req = 1'b1;
    next_r();
    next_r();
    n = 1;
    dbus_req = 1'b0;
    #1;
    check("drop_wait", 32'(dbus_wait), 0);
    flag_a = 1'b0;
    do begin
      next_r();
      n++;
      if (dbg_state == BSC_DONE) flag_a = 1'b1;
    end while (bsc_ack && n < 40);
    check("drop_lat", n, TB_WS + 1);
    check("drop_no_done", 32'(flag_a), 0);
    check("drop_di", dbus_di, 32'h0F0F_0F0F);
    check("drop_state", 32'(dbg_state), 32'(BSC_IDLE));
    check("drop_cs", 32'(mem_cs), 0);

    // Asynchronous reset in the middle of a write.
    dbus_a = 32'h0600_0500; dbus_we = 1'b1; dbus_do = 32'h1357_2468; dbus_ba = 4'hF; dbus_req = 1'b1;
    next_r();
    next_r();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_di", dbus_di, 0);
    check("mid_rst_mem_a", mem_a, 0);
    check("mid_rst_mem_do", mem_do, 0);
    check("mid_rst_mem_be", 32'(mem_be), 0);
    check("mid_rst_mem_we", 32'(mem_we), 0);
    check("mid_rst_mem_cs", 32'(mem_cs), 0);
    check("mid_rst_ack", 32'(bsc_ack), 0);
    check("mid_rst_back_n", 32'(back_n), 1);
    check("mid_rst_state", 32'(dbg_state), 32'(BSC_IDLE));
    dbus_req = 1'b0;
    #1;
    check("mid_rst_wait", 32'(dbus_wait), 0);
    #10 rst_n = 1'b1;
    next_r();
    next_r();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule

// File: doc/sh7604_dbus_resp.md
# sh7604_dbus_resp

Bus-side responder for the SH7604 internal DBUS. It accepts accesses from the DBUS initiator (DMAC or CPU data path) and runs them on a single external SRAM-style memory port with programmable wait states and burst beats. It generates DBUS_WAIT, returns read data, drives BSC_ACK for DACK generation, and arbitrates bus release to an external master under DBUS_LOCK.

## Interface
- WS, 1: wait states (CE_R periods) for a single or first-burst beat, 0..7
- BURST_WS, 0: wait states for burst beats 2..4, 0..7
- CLK in 1: system clock
- RST_N in 1: reset, asynchronous, active-low
- CE_R in 1, CE_F in 1: rising/falling phase clock enables
- DBUS_A in 32, DBUS_DO in 32, DBUS_BA in 4, DBUS_WE in 1: access address, write data, byte enables, write flag
- DBUS_REQ in 1, DBUS_BURST in 1, DBUS_LOCK in 1: request, burst beat, keep bus
- DBUS_DI out 32: read data, held
- DBUS_WAIT out 1: access not yet complete
- BSC_ACK out 1: external cycle in progress
- MEM_A out 32, MEM_DO out 32, MEM_BE out 4, MEM_WE out 1, MEM_CS out 1: external strobes
- MEM_DI in 32, MEM_RDY in 1: external read data, external ready
- BREQ_N in 1, BACK_N out 1: external bus request/acknowledge

## Operation
- States: IDLE, ACCESS, DONE, RELEASED, TURN (TURN only with macro).
- IDLE, CE_R: if BREQ_N=0 and DBUS_LOCK=0 -> RELEASED, BACK_N<=0; else if DBUS_REQ -> latch A/DO/BA/WE onto MEM_*, MEM_CS<=1, wait counter <= (DBUS_BURST and previous beat was burst) ? BURST_WS : WS -> ACCESS.
- ACCESS, CE_R: counter>0 decrements; counter=0 and MEM_RDY=1 -> if read, DBUS_DI<=MEM_DI; -> DONE. MEM_RDY=0 extends indefinitely.
- DONE, CE_F: access consumed; MEM_CS<=0. Next CE_R from IDLE rules; burst continuation (DBUS_REQ & DBUS_BURST still high) restarts ACCESS directly with BURST_WS, skipping IDLE.
- RELEASED: MEM_* at zero. CE_R with BREQ_N=1 -> BACK_N<=1 -> IDLE. DBUS_REQ waits with DBUS_WAIT=1.
- DBUS_WAIT = DBUS_REQ & (state != DONE), combinational.
- BSC_ACK = 1 in ACCESS and DONE.
- DBUS_DI is changed only by read completion. It holds the last read value through a following write, because the initiator forms single-mode write data from DBUS_DI.
- DBUS_REQ dropped during ACCESS: the external cycle completes. Read data is still latched. The state returns to IDLE without going to DONE.
- BREQ_N low while DBUS_LOCK=1: not granted until LOCK=0 in IDLE. Simultaneous new REQ and BREQ with LOCK=0: BREQ wins.
- RST_N low mid-access: all outputs return to reset values immediately; the external cycle is aborted.

## Timing
- Reset: DBUS_DI=0, MEM_A=0, MEM_DO=0, MEM_BE=0, MEM_WE=0, MEM_CS=0, BSC_ACK=0, BACK_N=1, state IDLE; DBUS_WAIT=0 while DBUS_REQ=0.
- Single access with MEM_RDY=1 and WS=N: the REQ-sampling CE_R is followed by N+1 CE_R periods to DONE. DBUS_WAIT falls before the next CE_F.
- WS=0: the access completes on the first CE_R after the launching one.
- Burst beat 2..4: BURST_WS+1 CE_R periods each, MEM_CS stays high across beats.

## Configuration
- SH7604_BSC_TURN_EN defined: after a read completes, if the next access is a write, enter TURN for one CE_R period with MEM_CS=0, then ACCESS. DBUS_WAIT stays high during TURN.
- Not defined: TURN is not present, and the write starts at the next CE_R.

## Structure
- Shared SH7604_PKG gains a state enum (BSC_STATE_t) and constants BSC_WS_MAX=7 and BSC_BURST_LEN=4.
- One sub-module, sh7604_bsc_waitcnt: a 3-bit loadable down-counter with zero flag, gated by CE_R.

## Test plan
- WS=2, single read at 0x06000004, MEM_DI=0xDEADBEEF -> DBUS_WAIT high 3 CE_R periods, DBUS_DI=0xDEADBEEF, BSC_ACK high for the whole access.
- Read 0x11223344, then write at BA=4'b0011 -> MEM_BE=0011, DBUS_DI still 0x11223344 after the write.
- 4-beat burst, WS=1, BURST_WS=0 -> beats take 2,1,1,1 CE_R periods; MEM_CS continuous; addresses +4.
- BREQ_N low during a locked burst -> BACK_N stays 1 until LOCK falls, then BACK_N=0 next CE_R; a REQ issued meanwhile is held with WAIT=1.
- MEM_RDY held low 5 CE_R periods -> WAIT extended 5 periods; RST_N pulse mid-access -> all outputs at reset values, state IDLE.
- With SH7604_BSC_TURN_EN: read then write -> one CE_R with MEM_CS=0 between them; without the macro -> no gap.
